// File: rtl/frame_color_analyzer_if.sv
// RAM read port plus result registers exchanged between the frame colour analyzer
// (master) and the surrounding top level / register file (slave).
interface frame_color_analyzer_if #(
    parameter int AW = 15,
    parameter int DW = 8
);
    logic          init;
    logic [DW-1:0] ram_data;
    logic [AW-1:0] ram_addr;
    logic          status;
    logic          done;
    logic [1:0]    color;
    logic [AW-1:0] cnt_red;
    logic [AW-1:0] cnt_green;
    logic [AW-1:0] cnt_blue;

    modport master (
        input  init, ram_data,
        output ram_addr, status, done, color, cnt_red, cnt_green, cnt_blue
    );

    modport slave (
        output init, ram_data,
        input  ram_addr, status, done, color, cnt_red, cnt_green, cnt_blue
    );
endinterface

// File: rtl/frame_color_analyzer.sv
// Scans one RGB332 frame from the synchronous frame-buffer read port, counts red,
// green and blue pixels and publishes the counts plus the dominant colour.
module frame_color_analyzer #(
    parameter int CAM_SCREEN_X = 160,
    parameter int CAM_SCREEN_Y = 120,
    parameter int AW           = 15,
    parameter int DW           = 8,
    parameter int HI_TH3       = 5,
    parameter int LO_TH3       = 2,
    parameter int HI_TH2       = 3,
    parameter int LO_TH2       = 1,
    parameter int MIN_COUNT    = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    frame_color_analyzer_if.master  bus
);
    localparam int            N       = CAM_SCREEN_X * CAM_SCREEN_Y;
    localparam logic [AW-1:0] LAST    = AW'(N - 1);
    localparam logic [AW-1:0] MIN_CNT = AW'(MIN_COUNT);
    localparam logic [2:0]    HI3     = 3'(HI_TH3);
    localparam logic [2:0]    LO3     = 3'(LO_TH3);
    localparam logic [1:0]    HI2     = 2'(HI_TH2);
    localparam logic [1:0]    LO2     = 2'(LO_TH2);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DECIDE} state_t;

    state_t        state, state_nx;
    logic          start, addr_inc, issue, load_res, last_addr;
    logic          pix_vld;
    logic [AW-1:0] acc_red, acc_green, acc_blue;
    logic [2:0]    pix_r, pix_g;
    logic [1:0]    pix_b;
    logic          is_red, is_green, is_blue;
    logic [AW-1:0] win_cnt;
    logic [1:0]    win_col;

    assign last_addr = (bus.ram_addr == LAST);

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // FSM: next state
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.init) state_nx = READ;
            READ:    if (last_addr) state_nx = DRAIN;
            DRAIN:   state_nx = DECIDE;
            DECIDE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM: control strobes
    always_comb begin
        start    = (state == IDLE) && bus.init;
        issue    = (state == READ);
        addr_inc = (state == READ) && !last_addr;
        load_res = (state == DECIDE);
    end

    // Pixel classification; the three classes are tested in priority order.
    assign pix_r    = bus.ram_data[DW-1 -: 3];
    assign pix_g    = bus.ram_data[DW-4 -: 3];
    assign pix_b    = bus.ram_data[1:0];
    assign is_red   = (pix_r >= HI3) && (pix_g <= LO3) && (pix_b <= LO2);
    assign is_green = !is_red && (pix_g >= HI3) && (pix_r <= LO3) && (pix_b <= LO2);
    assign is_blue  = !is_red && !is_green && (pix_b >= HI2) && (pix_r <= LO3) && (pix_g <= LO3);

    // Strict '>' keeps the earlier colour on ties: red > green > blue.
    always_comb begin
        win_col = 2'd1;
        win_cnt = acc_red;
        if (acc_green > win_cnt) begin
            win_col = 2'd2;
            win_cnt = acc_green;
        end
        if (acc_blue > win_cnt) begin
            win_col = 2'd3;
            win_cnt = acc_blue;
        end
        if (win_cnt < MIN_CNT) win_col = 2'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.ram_addr  <= '0;
            bus.status    <= 1'b0;
            bus.done      <= 1'b0;
            bus.color     <= 2'd0;
            bus.cnt_red   <= '0;
            bus.cnt_green <= '0;
            bus.cnt_blue  <= '0;
            pix_vld       <= 1'b0;
            acc_red       <= '0;
            acc_green     <= '0;
            acc_blue      <= '0;
        end else begin
            // RAM answers one clock after the address, so validity trails issue by one.
            pix_vld  <= issue;
            bus.done <= load_res;

            if (start)         bus.ram_addr <= '0;
            else if (addr_inc) bus.ram_addr <= bus.ram_addr + 1'b1;
            else if (load_res) bus.ram_addr <= '0;

            if (start)         bus.status <= 1'b1;
            else if (load_res) bus.status <= 1'b0;

            if (start) begin
                acc_red   <= '0;
                acc_green <= '0;
                acc_blue  <= '0;
            end else if (pix_vld) begin
                if (is_red)   acc_red   <= acc_red + 1'b1;
                if (is_green) acc_green <= acc_green + 1'b1;
                if (is_blue)  acc_blue  <= acc_blue + 1'b1;
            end

            if (load_res) begin
                bus.color     <= win_col;
                bus.cnt_red   <= acc_red;
                bus.cnt_green <= acc_green;
                bus.cnt_blue  <= acc_blue;
            end
        end
    end
endmodule

// File: tb/tb_frame_color_analyzer.sv
// Self-checking bench: a synchronous RAM model feeds frames, a pixel-by-pixel
// reference model predicts counts and dominant colour.
module tb_frame_color_analyzer;
    localparam int X  = 40;
    localparam int Y  = 30;
    localparam int N  = X * Y;
    localparam int AW = 15;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_pass = 0;
    int   n_tot  = 0;

    frame_color_analyzer_if #(.AW(AW), .DW(DW)) bus ();

    frame_color_analyzer #(.CAM_SCREEN_X(X), .CAM_SCREEN_Y(Y), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [N];
    always_ff @(posedge clk) bus.ram_data <= mem[bus.ram_addr];

    int exp_cnt [4];
    int exp_col;
    int lat, addr_err, stat_err;
    logic done_after, status_after;

    function automatic int cls(input logic [7:0] p);
        int r = int'(p) / 32;
        int g = (int'(p) / 4) % 8;
        int b = int'(p) % 4;
        if (r >= 5 && g <= 2 && b <= 1) return 1;
        if (g >= 5 && r <= 2 && b <= 1) return 2;
        if (b >= 3 && r <= 2 && g <= 2) return 3;
        return 0;
    endfunction

    task automatic model();
        int mx;
        exp_cnt = '{0, 0, 0, 0};
        for (int i = 0; i < N; i++) exp_cnt[cls(mem[i])]++;
        mx = exp_cnt[1];
        if (exp_cnt[2] > mx) mx = exp_cnt[2];
        if (exp_cnt[3] > mx) mx = exp_cnt[3];
        if (mx < 64)                 exp_col = 0;
        else if (exp_cnt[1] == mx)   exp_col = 1;
        else if (exp_cnt[2] == mx)   exp_col = 2;
        else                         exp_col = 3;
    endtask

    function automatic logic [7:0] rand_pix();
        int k = $urandom_range(0, 5);
        int r = $urandom_range(0, 7);
        int g = $urandom_range(0, 7);
        int b = $urandom_range(0, 3);
        if (k == 0) begin r = $urandom_range(5, 7); g = $urandom_range(0, 2); b = $urandom_range(0, 1); end
        if (k == 1) begin g = $urandom_range(5, 7); r = $urandom_range(0, 2); b = $urandom_range(0, 1); end
        if (k == 2) begin b = 3; r = $urandom_range(0, 2); g = $urandom_range(0, 2); end
        return 8'(r * 32 + g * 4 + b);
    endfunction

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < N; i++) mem[i] = v;
    endtask

    // Pulses init, follows the frame cycle by cycle and records what the DUT did.
    // poke_at >= 0 re-asserts init for 3 cycles in the middle of READ.
    task automatic run_frame(input int poke_at);
        model();
        @(negedge clk); bus.init = 1'b1;
        @(negedge clk); bus.init = 1'b0;
        lat = -1; addr_err = 0; stat_err = 0;
        for (int e = 0; e < N + 20; e++) begin
            bus.init = (poke_at >= 0) && (e >= poke_at) && (e < poke_at + 3);
            if (bus.done === 1'b1) begin lat = e; break; end
            if (e < N && bus.ram_addr !== AW'(e)) addr_err++;
            if (bus.status !== 1'b1) stat_err++;
            @(negedge clk);
        end
        bus.init = 1'b0;
        status_after = bus.status;
        @(negedge clk);
        done_after = bus.done;
    endtask

    task automatic test_reset();
        rst = 1'b0; bus.init = 1'b0;
        repeat (3) @(negedge clk);
        n_tot++; if (bus.status !== 1'b0) $display("FAIL reset_status got %b want 0", bus.status); else n_pass++;
        n_tot++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else n_pass++;
        n_tot++; if (bus.color !== 2'd0) $display("FAIL reset_color got %0d want 0", bus.color); else n_pass++;
        n_tot++; if (bus.ram_addr !== '0) $display("FAIL reset_addr got %0d want 0", bus.ram_addr); else n_pass++;
        n_tot++; if ({bus.cnt_red, bus.cnt_green, bus.cnt_blue} !== '0)
            $display("FAIL reset_cnts got %0d/%0d/%0d want 0/0/0", bus.cnt_red, bus.cnt_green, bus.cnt_blue);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_frame(input string nm);
        n_tot++; if (lat !== N + 2) $display("FAIL %s latency got %0d want %0d", nm, lat, N + 2); else n_pass++;
        n_tot++; if (addr_err !== 0) $display("FAIL %s addr_seq errors got %0d want 0", nm, addr_err); else n_pass++;
        n_tot++; if (stat_err !== 0) $display("FAIL %s status_busy errors got %0d want 0", nm, stat_err); else n_pass++;
        n_tot++; if (bus.cnt_red !== AW'(exp_cnt[1])) $display("FAIL %s cnt_red got %0d want %0d", nm, bus.cnt_red, exp_cnt[1]); else n_pass++;
        n_tot++; if (bus.cnt_green !== AW'(exp_cnt[2])) $display("FAIL %s cnt_green got %0d want %0d", nm, bus.cnt_green, exp_cnt[2]); else n_pass++;
        n_tot++; if (bus.cnt_blue !== AW'(exp_cnt[3])) $display("FAIL %s cnt_blue got %0d want %0d", nm, bus.cnt_blue, exp_cnt[3]); else n_pass++;
        n_tot++; if (bus.color !== 2'(exp_col)) $display("FAIL %s color got %0d want %0d", nm, bus.color, exp_col); else n_pass++;
        n_tot++; if (status_after !== 1'b0 || done_after !== 1'b0)
            $display("FAIL %s status/done_after got %b/%b want 0/0", nm, status_after, done_after);
        else n_pass++;
    endtask

    task automatic test_all_red();
        fill(8'hE0);
        run_frame(-1);
        check_frame("all_red");
        n_tot++; if (bus.cnt_red !== AW'(N) || bus.color !== 2'd1)
            $display("FAIL all_red_const got %0d/%0d want %0d/1", bus.cnt_red, bus.color, N);
        else n_pass++;
    endtask

    task automatic test_green_blue();
        fill(8'h00);
        for (int i = 0; i < 500; i++) mem[i] = 8'h1C;
        for (int i = 500; i < 800; i++) mem[i] = 8'h03;
        run_frame(-1);
        check_frame("green_blue");
        n_tot++; if (bus.cnt_green !== AW'(500) || bus.cnt_blue !== AW'(300) || bus.color !== 2'd2)
            $display("FAIL green_blue_const got %0d/%0d/%0d want 500/300/2", bus.cnt_green, bus.cnt_blue, bus.color);
        else n_pass++;
    endtask

    task automatic test_tie();
        for (int i = 0; i < N; i++) mem[i] = (i < N / 2) ? 8'hE0 : 8'h1C;
        run_frame(-1);
        check_frame("tie");
        n_tot++; if (bus.color !== 2'd1) $display("FAIL tie_red_wins got %0d want 1", bus.color); else n_pass++;
    endtask

    task automatic test_min_count();
        fill(8'h00);
        run_frame(-1);
        check_frame("black");
        for (int i = 0; i < 63; i++) mem[i * 17] = 8'hE0;
        run_frame(-1);
        check_frame("red63");
        n_tot++; if (bus.color !== 2'd0) $display("FAIL red63_none got %0d want 0", bus.color); else n_pass++;
        mem[N - 1] = 8'hE0;
        run_frame(-1);
        check_frame("red64");
        n_tot++; if (bus.color !== 2'd1) $display("FAIL red64_red got %0d want 1", bus.color); else n_pass++;
    endtask

    task automatic test_thresholds();
        fill(8'h00);
        for (int i = 0; i < 70; i++)  mem[i]       = 8'hA0;
        for (int i = 0; i < 50; i++)  mem[100 + i] = 8'h80;
        for (int i = 0; i < 40; i++)  mem[200 + i] = 8'h03;
        for (int i = 0; i < 30; i++)  mem[300 + i] = 8'h02;
        run_frame(-1);
        check_frame("thresh");
        n_tot++; if (bus.cnt_red !== AW'(70) || bus.cnt_blue !== AW'(40))
            $display("FAIL thresh_const got %0d/%0d want 70/40", bus.cnt_red, bus.cnt_blue);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N; i++) mem[i] = rand_pix();
            run_frame(-1);
            check_frame($sformatf("rand%0d", f));
        end
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] prev_red;
        int w, seen_done;
        prev_red = bus.cnt_red;
        for (int i = 0; i < N; i++) mem[i] = rand_pix();
        @(negedge clk); bus.init = 1'b1;
        @(negedge clk); bus.init = 1'b0;
        w = 0;
        while (bus.ram_addr !== AW'(N / 2) && w < N + 10) begin @(negedge clk); w++; end
        n_tot++; if (w >= N + 10) $display("FAIL rst_mid_reach timeout after %0d cycles want addr %0d", w, N / 2); else n_pass++;
        n_tot++; if (bus.cnt_red !== prev_red) $display("FAIL rst_mid_hold got %0d want %0d", bus.cnt_red, prev_red); else n_pass++;
        rst = 1'b0;
        #1;
        n_tot++; if ({bus.status, bus.done, bus.color, bus.ram_addr, bus.cnt_red, bus.cnt_green, bus.cnt_blue} !== '0)
            $display("FAIL rst_mid_clear got st=%b addr=%0d col=%0d r=%0d want all 0", bus.status, bus.ram_addr, bus.color, bus.cnt_red);
        else n_pass++;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        seen_done = 0;
        for (int e = 0; e < N + 10; e++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.status === 1'b1) seen_done++;
        end
        n_tot++; if (seen_done !== 0) $display("FAIL rst_mid_no_done got %0d busy/done cycles want 0", seen_done); else n_pass++;
        run_frame(N / 3);
        check_frame("after_rst_poke");
    endtask

    task automatic test_back_to_back();
        int w;
        for (int i = 0; i < N; i++) mem[i] = rand_pix();
        model();
        @(negedge clk); bus.init = 1'b1;
        w = 0;
        while (bus.done !== 1'b1 && w < N + 20) begin @(negedge clk); w++; end
        n_tot++; if (w !== N + 3) $display("FAIL b2b_first_done got %0d want %0d", w, N + 3); else n_pass++;
        @(negedge clk);
        n_tot++; if (bus.status !== 1'b1 || bus.done !== 1'b0)
            $display("FAIL b2b_restart got st=%b done=%b want 1/0", bus.status, bus.done);
        else n_pass++;
        bus.init = 1'b0;
        w = 0;
        while (bus.done !== 1'b1 && w < N + 20) begin @(negedge clk); w++; end
        n_tot++; if (w !== N + 2) $display("FAIL b2b_second_done got %0d want %0d", w, N + 2); else n_pass++;
        n_tot++; if (bus.cnt_red !== AW'(exp_cnt[1]) || bus.cnt_green !== AW'(exp_cnt[2]) ||
                     bus.cnt_blue !== AW'(exp_cnt[3]) || bus.color !== 2'(exp_col))
            $display("FAIL b2b_result got %0d/%0d/%0d c%0d want %0d/%0d/%0d c%0d", bus.cnt_red, bus.cnt_green,
                     bus.cnt_blue, bus.color, exp_cnt[1], exp_cnt[2], exp_cnt[3], exp_col);
        else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        bus.init = 1'b0;
        test_reset();
        test_all_red();
        test_green_blue();
        test_tie();
        test_min_count();
        test_thresholds();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
